// File: rtl/lane_logic_array_if.sv
// Handshake bundle for lane_logic_array: input transaction side and FIFO head side.
interface lane_logic_array_if #(
    parameter int NUM_LANES = 4,
    parameter int A_WIDTH   = 8
);
    logic                                in_valid;
    logic                                in_ready;
    logic [1:0]                          in_mode;
    logic [NUM_LANES-1:0][A_WIDTH-1:0]   in_a;
    logic [NUM_LANES-1:0][A_WIDTH-1:0]   in_b;
    logic [NUM_LANES-1:0][1:0]           in_c;
    logic                                out_valid;
    logic                                out_ready;
    logic [NUM_LANES-1:0]                out_d;
    logic [NUM_LANES-1:0]                out_e;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_d, out_e
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_d, out_e
    );
endinterface

// File: rtl/lane_logic_array.sv
// N-lane registered bit-reduction array: per-lane {d,e} results queued in a 2-entry FIFO,
// with per-lane saturating counters of delivered d=1 bits.
module lane_logic_array #(
    parameter int NUM_LANES   = 4,
    parameter int A_WIDTH     = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    lane_logic_array_if.slave                     bus,
    input  logic                                  clear_counts,
    output logic [NUM_LANES-1:0][COUNT_WIDTH-1:0] hit_count
);
    localparam int EW = 2 * NUM_LANES;

    typedef logic [EW-1:0] entry_t;

    function automatic logic [1:0] lane_fn(
        input logic [A_WIDTH-1:0] a,
        input logic [A_WIDTH-1:0] b,
        input logic [1:0]         c,
        input logic [1:0]         mode
    );
        logic [A_WIDTH-1:0] r;
        for (int k = 0; k < A_WIDTH; k++) begin
            r[k] = a[A_WIDTH-1-k];
        end
        case (mode)
            2'd1:    lane_fn = {|(a & b) & c[1], |(r & b) & c[0]};
            2'd2:    lane_fn = {^(a ^ b) ^ c[1], ^(r ^ b) ^ c[0]};
            default: lane_fn = {&(a | b) | c[1], &(r | b) | c[0]};
        endcase
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(
        input logic [COUNT_WIDTH-1:0] v,
        input logic                   hit
    );
        if (hit && (v != '1)) sat_inc = v + COUNT_WIDTH'(1);
        else                  sat_inc = v;
    endfunction

    logic [1:0]                            cnt_q, cnt_d;
    entry_t                                head_q, head_d;
    entry_t                                tail_q, tail_d;
    logic [NUM_LANES-1:0][COUNT_WIDTH-1:0] hit_q, hit_d;
    logic [NUM_LANES-1:0]                  new_d, new_e;
    logic                                  push, pop;

    // Ready/valid depend on registered occupancy only
    assign bus.in_ready  = (cnt_q != 2'd2);
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_d     = head_q[EW-1:NUM_LANES];
    assign bus.out_e     = head_q[NUM_LANES-1:0];
    assign hit_count     = hit_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        new_d = '0;
        new_e = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            {new_d[i], new_e[i]} = lane_fn(bus.in_a[i], bus.in_b[i], bus.in_c[i], bus.in_mode);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = {new_d, new_e};
                else               tail_d = {new_d, new_e};
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                tail_d = '0;
                cnt_d  = cnt_q - 2'd1;
            end
            // Push with pop implies cnt=1: the new entry replaces the departing head
            2'b11:   head_d = {new_d, new_e};
            default: ;
        endcase
    end

    always_comb begin
        hit_d = hit_q;
        if (clear_counts) begin
            hit_d = '0;
        end else if (pop) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                hit_d[i] = sat_inc(hit_q[i], bus.out_d[i]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            hit_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            hit_q  <= hit_d;
        end
    end
endmodule

// File: tb/tb_lane_logic_array.sv
// Directed bench for lane_logic_array: a 4x8 instance with a scoreboard and a 1x2 instance
// with 2-bit counters for the legacy-cell and saturation cases.
module tb_lane_logic_array;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    lane_logic_array_if #(.NUM_LANES(4), .A_WIDTH(8)) m_if ();
    lane_logic_array_if #(.NUM_LANES(1), .A_WIDTH(2)) s_if ();

    logic            m_clr, s_clr;
    logic [3:0][7:0] m_hit;
    logic [0:0][1:0] s_hit;

    lane_logic_array #(.NUM_LANES(4), .A_WIDTH(8), .COUNT_WIDTH(8)) dut_m (
        .clock(clock), .reset(reset), .bus(m_if.slave),
        .clear_counts(m_clr), .hit_count(m_hit)
    );

    lane_logic_array #(.NUM_LANES(1), .A_WIDTH(2), .COUNT_WIDTH(2)) dut_s (
        .clock(clock), .reset(reset), .bus(s_if.slave),
        .clear_counts(s_clr), .hit_count(s_hit)
    );

    int         n_checks = 0;
    int         n_errs   = 0;
    int         n_out;
    int         hit_exp[4];
    logic [7:0] exp_q[$];

    logic [31:0] bp_a[3] = '{32'h01234567, 32'hFFFF0000, 32'hA5A5A5A5};
    logic [31:0] bp_b[3] = '{32'h89ABCDEF, 32'h00FF00FF, 32'h5A5A5A5A};
    logic [7:0]  bp_c[3] = '{8'h1B, 8'hE4, 8'h00};
    logic [1:0]  bp_m[3] = '{2'd0, 2'd1, 2'd2};
    logic [3:0]  sw_d[3] = '{4'hF, 4'h0, 4'hF};
    logic [3:0]  sw_e[3] = '{4'hF, 4'hF, 4'hF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_lane(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] c, input logic [1:0] mode);
        logic and_ab = 1'b1, and_rb = 1'b1, or_ab = 1'b0, or_rb = 1'b0, x_ab = 1'b0, x_rb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            and_ab = and_ab & (a[k] | b[k]);
            and_rb = and_rb & (a[7-k] | b[k]);
            or_ab  = or_ab | (a[k] & b[k]);
            or_rb  = or_rb | (a[7-k] & b[k]);
            x_ab   = x_ab ^ a[k] ^ b[k];
            x_rb   = x_rb ^ a[7-k] ^ b[k];
        end
        if (mode == 2'd1)      return {or_ab & c[1], or_rb & c[0]};
        else if (mode == 2'd2) return {x_ab ^ c[1], x_rb ^ c[0]};
        else                   return {and_ab | c[1], and_rb | c[0]};
    endfunction

    function automatic logic [7:0] ref_vec();
        logic [3:0] d, e;
        logic [1:0] r;
        for (int i = 0; i < 4; i++) begin
            r    = ref_lane(m_if.in_a[i], m_if.in_b[i], m_if.in_c[i], m_if.in_mode);
            d[i] = r[1];
            e[i] = r[0];
        end
        return {d, e};
    endfunction

    // Called at a falling edge with inputs settled; books the transfers of the next rising edge.
    task automatic cycle_m();
        logic [7:0] h;
        if (m_if.out_valid && m_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(1), 32'(0));
            end else begin
                h = exp_q.pop_front();
                check("data", 32'({m_if.out_d, m_if.out_e}), 32'(h));
                for (int i = 0; i < 4; i++)
                    if (h[4+i] && hit_exp[i] < 255) hit_exp[i]++;
            end
            n_out++;
        end
        if (m_if.in_valid && m_if.in_ready) exp_q.push_back(ref_vec());
        @(negedge clock);
    endtask

    task automatic drive_bp(input int k);
        m_if.in_a    = bp_a[k];
        m_if.in_b    = bp_b[k];
        m_if.in_c    = bp_c[k];
        m_if.in_mode = bp_m[k];
    endtask

    initial begin
        int vcycles;
        int rdy_low;
        for (int i = 0; i < 4; i++) hit_exp[i] = 0;
        n_out = 0;
        m_if.in_valid = 1'b0; m_if.in_mode = 2'd0; m_if.in_a = '0; m_if.in_b = '0;
        m_if.in_c = '0; m_if.out_ready = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_mode = 2'd0; s_if.in_a = '0; s_if.in_b = '0;
        s_if.in_c = '0; s_if.out_ready = 1'b0;
        m_clr = 1'b0; s_clr = 1'b0;

        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(m_if.out_valid), 32'(0));
        check("rst_in_ready", 32'(m_if.in_ready), 32'(1));
        check("rst_hit", 32'(m_hit), 32'(0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Legacy two-bit cell
        s_if.in_a = 2'b01; s_if.in_b = 2'b10; s_if.in_c = 2'b00; s_if.in_mode = 2'd0;
        s_if.in_valid = 1'b1;
        @(negedge clock);
        s_if.in_valid = 1'b0;
        check("cell_valid", 32'(s_if.out_valid), 32'(1));
        check("cell_d", 32'(s_if.out_d), 32'(1));
        check("cell_e", 32'(s_if.out_e), 32'(0));

        // Clear beats the increment of a same-cycle d=1 delivery
        s_clr = 1'b1; s_if.out_ready = 1'b1;
        @(negedge clock);
        s_clr = 1'b0;
        check("clr_first", 32'(s_hit), 32'(0));
        check("clr_first_empty", 32'(s_if.out_valid), 32'(0));

        // Five d=1 deliveries into a 2-bit counter
        s_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 2) check("sat_partial", 32'(s_hit), 32'(2));
        end
        s_if.in_valid = 1'b0;
        @(negedge clock);
        check("sat_full", 32'(s_hit), 32'(3));
        check("sat_drained", 32'(s_if.out_valid), 32'(0));
        s_if.in_valid = 1'b1;
        @(negedge clock);
        s_if.in_valid = 1'b0;
        s_clr = 1'b1;
        @(negedge clock);
        s_clr = 1'b0;
        check("clr_with_hit", 32'(s_hit), 32'(0));

        // Mode sweep with hand-computed results, held under backpressure
        for (int md = 0; md < 3; md++) begin
            m_if.in_a = {4{8'hF0}}; m_if.in_b = {4{8'h0F}}; m_if.in_c = {4{2'b11}};
            m_if.in_mode = 2'(md); m_if.in_valid = 1'b1;
            cycle_m();
            m_if.in_valid = 1'b0;
            check("sweep_valid", 32'(m_if.out_valid), 32'(1));
            check("sweep_d", 32'(m_if.out_d), 32'(sw_d[md]));
            check("sweep_e", 32'(m_if.out_e), 32'(sw_e[md]));
            m_if.out_ready = 1'b1;
            cycle_m();
            m_if.out_ready = 1'b0;
        end
        m_if.in_a = 32'h12F081FF; m_if.in_b = 32'h300F7E00; m_if.in_c = 8'b10_01_00_11;
        m_if.in_mode = 2'd3; m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
        cycle_m();
        m_if.in_valid = 1'b0;
        cycle_m();

        // Backpressure: third transaction must wait for a free slot
        n_out = 0;
        m_if.out_ready = 1'b0;
        m_if.in_valid = 1'b1;
        drive_bp(0); cycle_m();
        drive_bp(1); cycle_m();
        drive_bp(2);
        check("bp_full_ready", 32'(m_if.in_ready), 32'(0));
        cycle_m();
        check("bp_still_full", 32'(m_if.in_ready), 32'(0));
        check("bp_hold", 32'({m_if.out_d, m_if.out_e}), 32'(exp_q[0]));
        m_if.out_ready = 1'b1;
        cycle_m();
        check("bp_slot_freed", 32'(m_if.in_ready), 32'(1));
        cycle_m();
        m_if.in_valid = 1'b0;
        cycle_m();
        check("bp_outs", 32'(n_out), 32'(3));
        check("bp_empty", 32'(m_if.out_valid), 32'(0));

        // Streaming at full rate
        n_out = 0; vcycles = 0; rdy_low = 0;
        m_if.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            m_if.in_a = $urandom; m_if.in_b = $urandom;
            m_if.in_c = 8'($urandom); m_if.in_mode = 2'($urandom);
            if (m_if.out_valid) vcycles++;
            if (!m_if.in_ready) rdy_low++;
            cycle_m();
        end
        m_if.in_valid = 1'b0;
        cycle_m();
        check("stream_outs", 32'(n_out), 32'(100));
        check("stream_valid_cycles", 32'(vcycles), 32'(99));
        check("stream_ready_low", 32'(rdy_low), 32'(0));
        for (int i = 0; i < 4; i++)
            check("hit_lane", 32'(m_hit[i]), 32'(hit_exp[i]));

        // Asynchronous reset with the FIFO full
        m_if.out_ready = 1'b0;
        m_if.in_valid = 1'b1;
        drive_bp(0); cycle_m();
        drive_bp(1); cycle_m();
        m_if.in_valid = 1'b0;
        check("pre_rst_full", 32'(m_if.in_ready), 32'(0));
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(m_if.out_valid), 32'(0));
        check("arst_in_ready", 32'(m_if.in_ready), 32'(1));
        check("arst_hit", 32'(m_hit), 32'(0));
        check("arst_data", 32'({m_if.out_d, m_if.out_e}), 32'(0));
        @(negedge clock);
        check("arst_in_ready_held", 32'(m_if.in_ready), 32'(1));
        reset = 1'b0;
        exp_q.delete();
        n_out = 0;
        m_if.out_ready = 1'b1;
        drive_bp(2);
        m_if.in_valid = 1'b1;
        cycle_m();
        m_if.in_valid = 1'b0;
        cycle_m();
        cycle_m();
        check("post_rst_outs", 32'(n_out), 32'(1));
        check("post_rst_empty", 32'(m_if.out_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
